// File: rtl/sbox_layer_seq.sv
// sbox_layer_seq: PRESENT-style 4-bit S-box layer applied LANES nibbles per
// cycle to a BLOCK_W-bit state, with valid/ready handshakes on both sides.
module sbox_layer_seq #(
  parameter int unsigned BLOCK_W = 64,
  parameter int unsigned LANES   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);

  localparam int unsigned NIB   = BLOCK_W / 4;
  localparam int unsigned STEPS = NIB / LANES;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t               fsm;
  logic [CNT_W-1:0]   cnt;
  logic               mode;
  logic [BLOCK_W-1:0] state;
  logic [BLOCK_W-1:0] sub_state;

  // Forward (inv=0) or inverse (inv=1) 4-bit S-box lookup.
  function automatic logic [3:0] sbox(input logic [3:0] x, input logic inv);
    logic [3:0] r;
    r = 4'h0;
    if (!inv) begin
      case (x)
        4'h0: r = 4'hC;  4'h1: r = 4'h5;  4'h2: r = 4'h6;  4'h3: r = 4'hB;
        4'h4: r = 4'h9;  4'h5: r = 4'h0;  4'h6: r = 4'hA;  4'h7: r = 4'hD;
        4'h8: r = 4'h3;  4'h9: r = 4'hE;  4'hA: r = 4'hF;  4'hB: r = 4'h8;
        4'hC: r = 4'h4;  4'hD: r = 4'h7;  4'hE: r = 4'h1;  4'hF: r = 4'h2;
        default: r = 4'h0;
      endcase
    end else begin
      case (x)
        4'h0: r = 4'h5;  4'h1: r = 4'hE;  4'h2: r = 4'hF;  4'h3: r = 4'h8;
        4'h4: r = 4'hC;  4'h5: r = 4'h1;  4'h6: r = 4'h2;  4'h7: r = 4'hD;
        4'h8: r = 4'hB;  4'h9: r = 4'h4;  4'hA: r = 4'h6;  4'hB: r = 4'h3;
        4'hC: r = 4'h0;  4'hD: r = 4'h7;  4'hE: r = 4'h9;  4'hF: r = 4'hA;
        default: r = 4'h0;
      endcase
    end
    return r;
  endfunction

  // Substitute the nibble group selected by the step counter; others pass through.
  always_comb begin
    sub_state = state;
    for (int unsigned n = 0; n < NIB; n++) begin
      if (CNT_W'(n / LANES) == cnt) begin
        sub_state[4*n +: 4] = sbox(state[4*n +: 4], mode);
      end
    end
  end

  // Control FSM with registered handshake outputs and in-place state update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      cnt       <= '0;
      mode      <= 1'b0;
      state     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state    <= in_data;
            mode     <= in_mode;
            cnt      <= '0;
            fsm      <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          state <= sub_state;
          if (cnt == CNT_W'(STEPS - 1)) begin
            cnt       <= '0;
            fsm       <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          fsm       <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = state;

endmodule

// File: doc/sbox_layer_seq.md
Name: sbox_layer_seq

Overview:
- Parametrised 4-bit S-box substitution layer for the PRESENT-style block cipher datapath.
- Applies the forward (encrypt) or inverse (decrypt) S-box to every nibble of a BLOCK_W-bit state.
- Processes LANES nibbles per clock, trading area against latency.
- Valid/ready handshake on both sides, so it drops in between the round-key XOR and permutation stages.

Parameters:
- BLOCK_W, 64, state width in bits; multiple of 4.
- LANES, 4, S-box instances used per cycle; must divide BLOCK_W/4 exactly. NIB = BLOCK_W/4, STEPS = NIB/LANES.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data/in_mode valid
- in_ready  output  1  block can accept a new state
- in_data  input  BLOCK_W  state to substitute
- in_mode  input  1  0 = forward S-box (encrypt), 1 = inverse S-box (decrypt)
- out_valid  output  1  out_data holds a finished result
- out_ready  input  1  downstream accepts result
- out_data  output  BLOCK_W  substituted state
- busy  output  1  high in RUN or DONE

Behaviour:
- Forward table, index 0..F: C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
- Inverse table, index 0..F: 5 E F 8 C 1 2 D B 4 6 3 0 7 9 A.
- The inverse must be the exact inverse of the forward table (bijection, no duplicate entries).
- Reset (rst_n low, async): state IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, step counter=0, mode register=0.
- FSM IDLE:
  - in_ready=1.
  - On in_valid at a clock edge: latch in_data into the state register, latch in_mode, counter=0, go to RUN.
- FSM RUN:
  - in_ready=0.
  - Each cycle, substitute nibbles [counter*LANES .. counter*LANES+LANES-1] of the state register in place, nibble 0 = bits [3:0].
  - Use the latched mode for the whole block.
  - Increment the counter. After the substitution at counter==STEPS-1, go to DONE.
- FSM DONE:
  - out_valid=1, in_ready=0.
  - out_data = state register, held stable until the handshake completes.
  - On out_ready, clear out_valid and return to IDLE next cycle.
- Latency: acceptance at edge T gives out_valid high after edge T+STEPS (LANES=NIB: after edge T+1).
  - Throughput: one block per STEPS+2 cycles, with out_ready held high.
- in_valid during RUN/DONE is ignored. Upstream must hold its data, since in_ready=0.
- in_mode and in_data changes after acceptance have no effect on the current block.
- out_ready while out_valid=0 is ignored.
- Counter width is clog2(STEPS) with a minimum of 1. With STEPS=1, RUN lasts exactly one cycle.
- Reset asserted mid-RUN or in DONE aborts immediately. The partial state is discarded, and all outputs return to their reset values asynchronously.
- out_data is don't-care-free: it always equals the state register, which is 0 after reset. Only its value while out_valid=1 is checked.
- No combinational path from in_valid/out_ready to in_ready/out_valid; all outputs are registered or decoded from the state only.

Test Plan:
- Encrypt, LANES=4: in_data=64'h0123456789ABCDEF, mode=0 -> out_data=64'hC56B90AD3EF84712, out_valid after edge T+4.
- Decrypt round-trip: feed 64'hC56B90AD3EF84712 with mode=1 -> 64'h0123456789ABCDEF.
  - Also: mode=1, in_data=64'h0123456789ABCDEF -> 64'h5EF8C12DB463079A.
- Parameter sweep, LANES=1/2/4/8/16 on the same vectors -> identical out_data, out_valid after edge T+16/8/4/2/1.
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> out_valid and out_data stable, in_ready=0.
  - Toggling in_valid/in_data/in_mode during RUN/DONE does not alter the result.
  - Raising out_ready -> IDLE, then accept the next block.
- Reset mid-RUN: assert rst_n=0 after edge T+2 (LANES=4) -> out_valid=0, out_data=0, in_ready=1 immediately.
  - After release, a fresh block 64'hFFFFFFFFFFFFFFFF with mode=0 gives 64'h2222222222222222.
- Exhaustive nibble check, LANES=16, all 16 values replicated across the state, both modes -> each result matches the tables; forward-then-inverse returns the original.
